// File: rtl/disp_tx_fifo_if.sv
// Bus bundle for disp_tx_fifo: CPU register port plus the display write port.
// The slave side is the FIFO block; the master side is whoever drives the CPU bus.
interface disp_tx_fifo_if;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic [31:0] out_daddr;
  logic [31:0] out_dwdata;
  logic [3:0]  out_dwe;

  modport master (
    output daddr, dwdata, dwe,
    input  drdata, out_daddr, out_dwdata, out_dwe
  );

  modport slave (
    input  daddr, dwdata, dwe,
    output drdata, out_daddr, out_dwdata, out_dwe
  );
endinterface

// File: rtl/disp_tx_fifo.sv
// Memory-mapped character FIFO between the CPU bus and the display peripheral.
// A drain FSM replays queued characters as single-cycle writes, DRAIN_GAP idle cycles apart.
module disp_tx_fifo #(
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4,
  parameter int          DRAIN_GAP = 2,
  parameter logic [31:0] BASE_ADDR = 32'h00034570,
  parameter logic [31:0] DISP_ADDR = 32'h00034560
) (
  input logic           clk,
  input logic           reset,
  disp_tx_fifo_if.slave bus
);
  localparam int          GW        = $clog2(DRAIN_GAP + 1);
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_level;
  logic [15:0]   r_total_cnt;
  logic          r_overflow;
  state_t        r_state;
  logic [GW-1:0] r_gap_cnt;
  logic [31:0]   r_out_daddr;
  logic [31:0]   r_out_dwdata;
  logic [3:0]    r_out_dwe;

  logic w_push, w_ctrl, w_flush, w_clr_ovf;
  logic w_full, w_empty, w_pop, w_accept, w_drop;
  logic w_unused;

  assign w_push    = (bus.daddr == BASE_ADDR) && bus.dwe[0];
  assign w_ctrl    = (bus.daddr == CTRL_ADDR) && bus.dwe[0];
  assign w_flush   = w_ctrl && bus.dwdata[0];
  assign w_clr_ovf = w_ctrl && bus.dwdata[1];
  assign w_full    = (r_level == (AW+1)'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  // A full FIFO still takes a push when the drain frees a slot on the same edge.
  assign w_accept  = w_push && !w_flush && (!w_full || w_pop);
  assign w_drop    = w_push && !w_flush && w_full && !w_pop;
  assign w_unused  = ^{bus.dwe[3:1], bus.dwdata[31:8]};

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= bus.dwdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_level     <= '0;
      r_total_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_accept && !w_pop)      r_level <= r_level + 1'b1;
        else if (!w_accept && w_pop) r_level <= r_level - 1'b1;
      end
      if (w_accept) r_total_cnt <= r_total_cnt + 16'd1;
      if (w_drop)         r_overflow <= 1'b1;
      else if (w_clr_ovf) r_overflow <= 1'b0;
    end
  end

  // Drain FSM; the head is read straight into the output register, so the RAM read is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_gap_cnt    <= '0;
      r_out_daddr  <= '0;
      r_out_dwdata <= '0;
      r_out_dwe    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_out_dwdata <= {24'b0, r_mem[r_rd_ptr]};
            r_out_daddr  <= DISP_ADDR;
            r_out_dwe    <= 4'b0001;
            r_state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_out_dwe   <= '0;
          r_out_daddr <= '0;
          r_gap_cnt   <= GW'(DRAIN_GAP - 1);
          r_state     <= S_GAP;
        end
        S_GAP: begin
          if (r_gap_cnt == '0) r_state   <= S_IDLE;
          else                 r_gap_cnt <= r_gap_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.drdata = '0;
    if (bus.daddr == STAT_ADDR)
      bus.drdata = {r_total_cnt, 8'(r_level), 5'b0, r_overflow, w_full, w_empty};
  end

  assign bus.out_daddr  = r_out_daddr;
  assign bus.out_dwdata = r_out_dwdata;
  assign bus.out_dwe    = r_out_dwe;
endmodule

// File: doc/disp_tx_fifo.md
Name: disp_tx_fifo

Overview:
- Memory-mapped character output buffer between the CPU data bus and the display peripheral.
- CPU writes characters to a DATA register; the block queues them in a FIFO.
- A drain FSM replays each character as a single-cycle write to the display peripheral's character address, spaced DRAIN_GAP cycles apart.
- A STATUS register exposes the FIFO level, full/empty/overflow flags and the count of accepted characters.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..128.
- AW, 4, log2(DEPTH).
- DRAIN_GAP, 2, idle cycles after each display write; must be ≥1.
- BASE_ADDR, 32'h00034570, DATA register address; STATUS = BASE+4, CTRL = BASE+8.
- DISP_ADDR, 32'h00034560, display character address driven on out_daddr.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- daddr  in  32  CPU bus address.
- dwdata  in  32  CPU write data.
- dwe  in  4  CPU byte write enables.
- drdata  out  32  CPU read data; combinational from daddr.
- out_daddr  out  32  display bus address.
- out_dwdata  out  32  display write data; char in [7:0], upper bits zero.
- out_dwe  out  4  display byte enables; 4'b0001 during a write, else 0.

Behaviour:
- Reset (synchronous, active-high, sampled on clk rising edge):
  - FIFO empty; rd/wr pointers 0; level 0; total_cnt 0; overflow 0.
  - FSM in IDLE; out_dwe=0, out_dwdata=0, out_daddr=0.
  - Reset mid-drain aborts the drain; queued characters are discarded.
- Push:
  - A push is an edge with daddr==BASE_ADDR and dwe[0]==1; it stores dwdata[7:0].
  - dwe!=0 with dwe[0]==0 at BASE_ADDR is ignored.
- Full:
  - A push while full and no pop this edge is dropped; overflow is set (sticky) and total_cnt is unchanged.
  - A push while full on the same edge as a pop is accepted; level stays DEPTH.
- total_cnt: 16-bit count of accepted pushes; wraps 16'hFFFF→0.
- CTRL write (daddr==BASE+8, dwe[0]==1):
  - dwdata[0]=1 flushes: pointers and level reset to 0.
  - dwdata[1]=1 clears overflow.
  - A push on the same edge as a flush is lost and not counted.
  - Flush does not reset total_cnt or the FSM; an out_dwe pulse already in progress completes.
- drdata, combinational:
  - At BASE+4: {total_cnt[15:0], level[7:0], 5'b0, overflow, full, empty}.
  - At BASE: 0. At BASE+8: {30'b0, 2'b0}. Any other address: 0.
- Drain FSM, with registered outputs:
  - IDLE: if FIFO is not empty, pop the head; out_dwdata←{24'b0, head}, out_daddr←DISP_ADDR, out_dwe←4'b0001; go to WRITE.
  - WRITE (one cycle): out_dwe←0, out_daddr←0; gap_cnt←DRAIN_GAP-1; go to GAP.
  - GAP: if gap_cnt==0 go to IDLE, else gap_cnt−1.
- Timing:
  - Latency: push at edge E into an empty idle FIFO → out_dwe high for exactly the cycle between edges E+1 and E+2.
  - Steady-state spacing between out_dwe pulses = DRAIN_GAP+2 cycles.
  - out_dwdata holds its value after the pulse until the next load.
- Pointer wrap: pointers are AW bits and wrap mod DEPTH. full = (level==DEPTH); empty = (level==0).

Test Plan:
- Reset then idle 10 cycles → out_dwe stays 0; STATUS read = 32'h00000001.
- Push 'H' (8'h48) then 'i' (8'h69) back-to-back:
  - out_dwe=4'b0001 with out_dwdata=32'h48 one cycle after the first push.
  - A second pulse with 32'h69 follows 4 cycles later.
  - STATUS ends at 32'h00020001.
- Push 17 chars 0x41..0x51 on consecutive cycles, DRAIN_GAP=20:
  - The first pops after 1 cycle, so the 17th push is accepted; an 18th push is dropped.
  - overflow=1; total_cnt=17.
  - The drain emits 0x41..0x51 in order.
- Fill 5 chars, then CTRL write 32'h3 → level 0, overflow 0, total_cnt unchanged; at most one further out_dwe pulse (the one already in flight).
- Assert reset during GAP with 3 chars queued → all outputs 0 the next cycle; no further pulses; STATUS = 32'h00000001.
- Write 65537 chars with the drain keeping pace → total_cnt reads 1; write with dwe=4'b0010 at BASE → ignored.
